// File: rtl/fnd_pkg.sv
// fnd_pkg: segment patterns and code constants shared by the FND decode and capture paths.
package fnd_pkg;
   localparam logic [6:0] SEG_0     = 7'b111_1110;
   localparam logic [6:0] SEG_1     = 7'b011_0000;
   localparam logic [6:0] SEG_2     = 7'b110_1101;
   localparam logic [6:0] SEG_3     = 7'b111_1001;
   localparam logic [6:0] SEG_4     = 7'b011_0011;
   localparam logic [6:0] SEG_5     = 7'b101_1011;
   localparam logic [6:0] SEG_6     = 7'b101_1111;
   localparam logic [6:0] SEG_7     = 7'b111_0000;
   localparam logic [6:0] SEG_8     = 7'b111_1111;
   localparam logic [6:0] SEG_9     = 7'b111_0011;
   localparam logic [6:0] SEG_BLANK = 7'b000_0000;
   localparam logic [3:0] NUM_BLANK   = 4'hF;
   localparam logic [3:0] NUM_INVALID = 4'hE;
   typedef struct packed {
      logic [3:0] code;
      logic       invalid;
   } enc_t;
endpackage

// File: rtl/fnd_enc.sv
// fnd_enc: maps a segment pattern back to its BCD code, flagging patterns outside the map.
module fnd_enc
   import fnd_pkg::*;
(
   input  logic [6:0] i_seg,
   output enc_t       o_enc
);
   always_comb begin
      o_enc = '{code: NUM_INVALID, invalid: 1'b1};
      case (i_seg)
         SEG_0:     o_enc = '{code: 4'd0, invalid: 1'b0};
         SEG_1:     o_enc = '{code: 4'd1, invalid: 1'b0};
         SEG_2:     o_enc = '{code: 4'd2, invalid: 1'b0};
         SEG_3:     o_enc = '{code: 4'd3, invalid: 1'b0};
         SEG_4:     o_enc = '{code: 4'd4, invalid: 1'b0};
         SEG_5:     o_enc = '{code: 4'd5, invalid: 1'b0};
         SEG_6:     o_enc = '{code: 4'd6, invalid: 1'b0};
         SEG_7:     o_enc = '{code: 4'd7, invalid: 1'b0};
         SEG_8:     o_enc = '{code: 4'd8, invalid: 1'b0};
         SEG_9:     o_enc = '{code: 4'd9, invalid: 1'b0};
         SEG_BLANK: o_enc = '{code: NUM_BLANK, invalid: 1'b0};
         default:   ;
      endcase
   end
endmodule

// File: rtl/fnd_cap.sv
// fnd_cap: recovers per-digit BCD codes from a multiplexed 7-segment bus once each
// pattern has been stable for STABLE_CNT samples; pulses when every position is refreshed.
module fnd_cap
   import fnd_pkg::*;
#(
   parameter int DIGITS     = 6,
   parameter int STABLE_CNT = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [6:0]            i_seg,
   input  logic [DIGITS-1:0]     i_com,
   output logic [4*DIGITS-1:0]   o_num,
   output logic [DIGITS-1:0]     o_err,
   output logic                  o_frame_vld,
   output logic                  o_bus_err
);
   logic [DIGITS+6:0]   r_s;
   logic [3:0]          r_cnt;
   logic                r_acc;
   logic [DIGITS-1:0]   r_mask;
   logic [4*DIGITS-1:0] r_num;
   logic [DIGITS-1:0]   r_err;
   logic                r_frame;
   logic                r_bus;
   logic [DIGITS+6:0]   w_smp;
   logic [DIGITS-1:0]   w_com;
   logic [DIGITS-1:0]   w_mask_nxt;
   logic                w_same;
   logic                w_onehot;
   enc_t                w_enc;

   assign w_smp      = {i_com, i_seg};
   assign w_same     = w_smp == r_s;
   assign w_com      = r_s[DIGITS+6:7];
   assign w_onehot   = (w_com != '0) && ((w_com & (w_com - 1'b1)) == '0);
   assign w_mask_nxt = r_mask | w_com;

   fnd_enc u_enc (.i_seg(r_s[6:0]), .o_enc(w_enc));

   // r_acc marks the edge after the run became stable; r_s still holds that pattern then
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s     <= '0;
         r_cnt   <= '0;
         r_acc   <= 1'b0;
         r_mask  <= '0;
         r_num   <= {DIGITS{NUM_BLANK}};
         r_err   <= '0;
         r_frame <= 1'b0;
         r_bus   <= 1'b0;
      end else begin
         r_s     <= w_smp;
         r_cnt   <= !w_same ? 4'd1 : (r_cnt == 4'(STABLE_CNT) ? r_cnt : r_cnt + 4'd1);
         r_acc   <= w_same && (r_cnt == 4'(STABLE_CNT - 1));
         r_frame <= r_acc && w_onehot && (&w_mask_nxt);
         r_bus   <= r_acc && (w_com != '0) && !w_onehot;
         if (r_acc && w_onehot) begin
            for (int n = 0; n < DIGITS; n++) begin
               if (w_com[n]) begin
                  r_num[4*n +: 4] <= w_enc.code;
                  r_err[n]        <= w_enc.invalid;
               end
            end
            r_mask <= (&w_mask_nxt) ? '0 : w_mask_nxt;
         end
      end
   end

   assign o_num       = r_num;
   assign o_err       = r_err;
   assign o_frame_vld = r_frame;
   assign o_bus_err   = r_bus;
endmodule

// File: tb/tb_fnd_cap.sv
// tb_fnd_cap: directed-vector bench for fnd_cap with hand-computed expectations.
module tb_fnd_cap;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [6:0]  i_seg;
   logic [5:0]  i_com;
   logic [23:0] o_num;
   logic [5:0]  o_err;
   logic        o_frame_vld;
   logic        o_bus_err;

   int n_chk = 0;
   int n_err = 0;
   int n_frame = 0;
   int n_bus = 0;
   int n_both = 0;
   int f0;
   int b0;

   logic [6:0] seg_lut [10] = '{7'b111_1110, 7'b011_0000, 7'b110_1101, 7'b111_1001, 7'b011_0011,
                                7'b101_1011, 7'b101_1111, 7'b111_0000, 7'b111_1111, 7'b111_0011};

   fnd_cap #(.DIGITS(6), .STABLE_CNT(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_seg(i_seg), .i_com(i_com),
      .o_num(o_num), .o_err(o_err), .o_frame_vld(o_frame_vld), .o_bus_err(o_bus_err)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_frame_vld) n_frame++;
      if (o_bus_err) n_bus++;
      if (o_frame_vld && o_bus_err) n_both++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic [5:0] c, input logic [6:0] s, input int n);
      i_com = c;
      i_seg = s;
      repeat (n) @(negedge i_clk);
      #1;
   endtask

   task automatic scan(input int d, input int v);
      hold(6'(1 << d), seg_lut[v], 6);
      hold(6'd0, 7'd0, 2);
   endtask

   initial begin
      i_rst = 1'b1;
      hold(6'd0, 7'd0, 2);
      check("rst_num", 32'(o_num), 32'hFFFFFF);
      check("rst_err", 32'(o_err), 32'h0);
      i_rst = 1'b0;
      hold(6'd0, 7'd0, 6);
      check("idle_num", 32'(o_num), 32'hFFFFFF);
      check("idle_err", 32'(o_err), 32'h0);
      check("idle_pulses", 32'(n_frame + n_bus), 32'd0);

      hold(6'b000001, 7'b111_1001, 3);
      hold(6'b000001, 7'b111_1001, 1);
      check("lat_early", 32'(o_num), 32'hFFFFFF);
      hold(6'd0, 7'd0, 1);
      check("lat_num", 32'(o_num), 32'hFFFFF3);
      check("lat_err", 32'(o_err), 32'h0);
      hold(6'd0, 7'd0, 2);
      check("lat_frame", 32'(n_frame), 32'd0);

      scan(0, 1); scan(1, 2); scan(2, 3); scan(3, 4); scan(4, 5);
      check("scan_nofr", 32'(n_frame), 32'd0);
      hold(6'b100000, seg_lut[9], 5);
      check("scan_fv_hi", 32'(o_frame_vld), 32'd1);
      check("scan_num", 32'(o_num), 32'h954321);
      hold(6'b100000, seg_lut[9], 1);
      check("scan_fv_lo", 32'(o_frame_vld), 32'd0);
      hold(6'd0, 7'd0, 2);
      check("scan_cnt1", 32'(n_frame), 32'd1);
      for (int d = 0; d < 6; d++) scan(d, (d == 5) ? 9 : d + 1);
      check("rescan_cnt", 32'(n_frame), 32'd2);
      check("rescan_num", 32'(o_num), 32'h954321);

      hold(6'b000100, 7'b100_0001, 6);
      check("inv_num", 32'(o_num[11:8]), 32'hE);
      check("inv_err", 32'(o_err), 32'b000100);
      hold(6'b000100, 7'b011_0000, 6);
      check("fix_num", 32'(o_num[11:8]), 32'h1);
      check("fix_err", 32'(o_err), 32'h0);
      hold(6'd0, 7'd0, 2);

      f0 = n_frame;
      b0 = n_bus;
      hold(6'b000010, seg_lut[8], 3);
      hold(6'b000011, seg_lut[8], 12);
      hold(6'd0, 7'd0, 2);
      check("bus_pulse", 32'(n_bus - b0), 32'd1);
      check("bus_num", 32'(o_num), 32'h954121);
      check("bus_frame", 32'(n_frame - f0), 32'd0);

      hold(6'b001000, 7'd0, 6);
      hold(6'd0, 7'd0, 2);
      check("blank_num", 32'(o_num), 32'h95F121);
      check("blank_err", 32'(o_err), 32'h0);

      hold(6'b000001, 7'b100_0001, 6);
      hold(6'd0, 7'd0, 2);
      check("pre_err", 32'(o_err), 32'b000001);
      scan(1, 5);
      i_rst = 1'b1;
      hold(6'd0, 7'd0, 1);
      check("mrst_num", 32'(o_num), 32'hFFFFFF);
      check("mrst_err", 32'(o_err), 32'h0);
      i_rst = 1'b0;
      f0 = n_frame;
      scan(3, 7); scan(4, 8); scan(5, 0);
      check("post3_fr", 32'(n_frame - f0), 32'd0);
      scan(0, 6); scan(1, 1);
      check("post5_fr", 32'(n_frame - f0), 32'd0);
      scan(2, 2);
      check("post6_fr", 32'(n_frame - f0), 32'd1);
      check("post_num", 32'(o_num), 32'h087216);
      check("excl", 32'(n_both), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
